// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle between the core's master port and axi_sram_slave.
// Signal names mirror the io_slave_* port list with the prefix dropped.
interface axi_sram_slave_if;
  logic        awready;
  logic        awvalid;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wready;
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arready;
  logic        arvalid;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rready;
  logic        rvalid;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        rlast;
  logic [3:0]  rid;

  modport slave (
    output awready, wready, bvalid, bresp, bid,
    output arready, rvalid, rresp, rdata, rlast, rid,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready
  );

  modport master (
    input  awready, wready, bvalid, bresp, bid,
    input  arready, rvalid, rresp, rdata, rlast, rid,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, rready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 SRAM slave, one outstanding transaction, configurable read latency.
// Define AXI_SRAM_RAND_DELAY_EN to add LFSR-driven handshake stalls.
module axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  axi_sram_slave_if.slave  io_slave
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned LAT_W = 16;
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [1:0]  DECERR = 2'b11;
  localparam logic [1:0]  FIXED  = 2'b00;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         id_q, id_d;
  logic [7:0]         len_q, len_d;
  logic [1:0]         burst_q, burst_d;
  logic [8:0]         beat_q, beat_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         resp_q, resp_d;

  logic [31:0]        mem_q [DEPTH_WORDS];
  logic               mem_we;
  logic [IDX_W-1:0]   cur_idx;
  logic               cur_oor;
  logic [31:0]        next_addr;
  logic               idle_open;
  logic               beat_open;
  logic               wr_slv;
  logic               unused_sizes;

  assign unused_sizes = ^{io_slave.awsize, io_slave.arsize};

  // Word 0 sits at BASE_ADDR; the 33-bit compare keeps BASE+size from overflowing.
  assign cur_idx   = IDX_W'((addr_q - BASE_ADDR) >> 2);
  assign cur_oor   = (addr_q < BASE_ADDR) || ({1'b0, addr_q} >= END_ADDR);
  assign next_addr = (burst_q == FIXED) ? addr_q : addr_q + 32'd4;

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;
  logic [2:0] hold_q;
  logic [1:0] gap_q;
  logic       txn_done;
  logic       beat_taken;

  assign beat_taken = (state_q == RD_DATA) && io_slave.rvalid && io_slave.rready;
  assign txn_done   = (beat_taken && io_slave.rlast) ||
                      ((state_q == WR_RESP) && io_slave.bready);
  assign idle_open  = reset && (hold_q == 3'd0);
  assign beat_open  = (gap_q == 2'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 8'hA5;
      hold_q <= '0;
      gap_q  <= '0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      if (txn_done)              hold_q <= lfsr_q[2:0];
      else if (hold_q != 3'd0)   hold_q <= hold_q - 3'd1;
      if (beat_taken && !io_slave.rlast) gap_q <= lfsr_q[1:0];
      else if (gap_q != 2'd0)            gap_q <= gap_q - 2'd1;
    end
  end
`else
  assign idle_open = reset;
  assign beat_open = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (io_slave.wstrb[i]) mem_q[cur_idx][8*i +: 8] <= io_slave.wdata[8*i +: 8];
      end
    end
  end

  // Write error: wlast early, or the awlen+1-th beat arrives without wlast.
  assign wr_slv = io_slave.wlast ? (beat_q != {1'b0, len_q})
                                 : (beat_q >= {1'b0, len_q});

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    mem_we  = 1'b0;
    io_slave.awready = 1'b0;
    io_slave.arready = 1'b0;
    io_slave.wready  = 1'b0;
    io_slave.bvalid  = 1'b0;
    io_slave.bresp   = '0;
    io_slave.bid     = '0;
    io_slave.rvalid  = 1'b0;
    io_slave.rresp   = '0;
    io_slave.rdata   = '0;
    io_slave.rlast   = 1'b0;
    io_slave.rid     = '0;

    case (state_q)
      IDLE: begin
        io_slave.awready = idle_open;
        io_slave.arready = idle_open && !io_slave.awvalid;
        if (idle_open && io_slave.awvalid) begin
          addr_d  = io_slave.awaddr;
          id_d    = io_slave.awid;
          len_d   = io_slave.awlen;
          burst_d = io_slave.awburst;
          beat_d  = '0;
          resp_d  = OKAY;
          state_d = WR_DATA;
        end else if (idle_open && io_slave.arvalid) begin
          addr_d  = io_slave.araddr;
          id_d    = io_slave.arid;
          len_d   = io_slave.arlen;
          burst_d = io_slave.arburst;
          beat_d  = '0;
          cnt_d   = LAT_W'(READ_LATENCY - 1);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) state_d = RD_DATA;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RD_DATA: begin
        io_slave.rvalid = beat_open;
        io_slave.rid    = id_q;
        io_slave.rlast  = beat_open && (beat_q == {1'b0, len_q});
        io_slave.rresp  = cur_oor ? DECERR : OKAY;
        io_slave.rdata  = cur_oor ? '0 : mem_q[cur_idx];
        if (beat_open && io_slave.rready) begin
          addr_d = next_addr;
          beat_d = beat_q + 9'd1;
          if (beat_q == {1'b0, len_q}) state_d = IDLE;
        end
      end
      WR_DATA: begin
        io_slave.wready = 1'b1;
        if (io_slave.wvalid) begin
          mem_we = !cur_oor;
          addr_d = next_addr;
          beat_d = beat_q + 9'd1;
          if (wr_slv)                             resp_d = SLVERR;
          else if (cur_oor && resp_q != SLVERR)   resp_d = DECERR;
          if (io_slave.wlast) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        io_slave.bvalid = 1'b1;
        io_slave.bresp  = resp_q;
        io_slave.bid    = id_q;
        if (io_slave.bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave (default timing build).
module tb_axi_sram_slave;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] wd     [8];
  logic [31:0] exp_rd [8];
  logic [1:0]  exp_rr [8];

  axi_sram_slave_if bus();

  axi_sram_slave #(
    .BASE_ADDR   (32'h8000_0000),
    .DEPTH_WORDS (4096),
    .READ_LATENCY(2)
  ) dut (
    .clock   (clk),
    .reset   (rst_n),
    .io_slave(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                    input int nb, input logic [3:0] strb,
                    output logic [1:0] resp, output logic [3:0] bid);
    bit ok;
    resp = '1;
    bid  = '0;
    bus.awaddr = addr; bus.awid = id; bus.awlen = len;
    bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk); ok = bus.awready; @(posedge clk); #1;
    end
    bus.awvalid = 1'b0;
    chk("aw_handshake", 32'(ok), 32'd1);
    if (!ok) return;
    for (int i = 0; i < nb; i++) begin
      bus.wvalid = 1'b1; bus.wdata = wd[i]; bus.wstrb = strb; bus.wlast = (i == nb - 1);
      ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
        @(negedge clk); ok = bus.wready; @(posedge clk); #1;
      end
      if (!ok) begin
        chk("w_handshake", 32'(ok), 32'd1);
        bus.wvalid = 1'b0;
        return;
      end
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (bus.bvalid) begin
        ok = 1'b1; resp = bus.bresp; bid = bus.bid;
        chk("b_delay", 32'(n), 32'd0);
      end
      @(posedge clk); #1;
    end
    bus.bready = 1'b0;
    chk("b_seen", 32'(ok), 32'd1);
  endtask

  // Expected beats come from exp_rd/exp_rr; every rvalid cycle (stalled or not) is checked.
  task automatic rd(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                    input bit toggle, output int lat);
    bit ok;
    bit seen;
    bit done;
    int beat;
    int c;
    lat = 0;
    bus.araddr = addr; bus.arid = id; bus.arlen = len;
    bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk); ok = bus.arready; @(posedge clk); #1;
    end
    bus.arvalid = 1'b0;
    chk("ar_handshake", 32'(ok), 32'd1);
    if (!ok) return;
    seen = 1'b0; done = 1'b0; beat = 0; c = 0;
    bus.rready = 1'b1;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (bus.rvalid) begin
        seen = 1'b1;
        chk("rdata", bus.rdata, exp_rd[beat]);
        chk("rresp", 32'(bus.rresp), 32'(exp_rr[beat]));
        chk("rlast", 32'(bus.rlast), 32'(beat == int'(len)));
        chk("rid", 32'(bus.rid), 32'(id));
        if (bus.rready) begin
          if (beat == int'(len)) done = 1'b1;
          beat++;
        end
      end else if (!seen) begin
        lat++;
      end
      @(posedge clk); #1;
      c++;
      bus.rready = toggle ? (c % 2 == 0) : 1'b1;
    end
    bus.rready = 1'b0;
    chk("r_done", 32'(done), 32'd1);
  endtask

  initial begin
    logic [1:0] resp;
    logic [3:0] bid;
    int lat;
    bit ok;

    bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    bus.rready = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single word write then read with latency measurement
    wd[0] = 32'h0000_0413;
    wr(32'h8000_0000, 4'h5, 8'd0, 1, 4'hF, resp, bid);
    chk("w1_bresp", 32'(resp), 32'd0);
    chk("w1_bid", 32'(bid), 32'd5);
    exp_rd[0] = 32'h0000_0413; exp_rr[0] = 2'b00;
    rd(32'h8000_0000, 4'h9, 8'd0, 1'b0, lat);
    chk("r1_latency", 32'(lat), 32'd2);

    // byte strobe merge
    wd[0] = 32'h1122_3344;
    wr(32'h8000_0004, 4'h1, 8'd0, 1, 4'hF, resp, bid);
    wd[0] = 32'hAABB_CCDD;
    wr(32'h8000_0004, 4'h2, 8'd0, 1, 4'b0100, resp, bid);
    chk("strb_bresp", 32'(resp), 32'd0);
    exp_rd[0] = 32'h11BB_3344; exp_rr[0] = 2'b00;
    rd(32'h8000_0004, 4'h3, 8'd0, 1'b0, lat);

    // 4-beat burst write then 4-beat read with rready toggling
    wd[0] = 32'hA0A0_0010; wd[1] = 32'hA1A1_0014; wd[2] = 32'hA2A2_0018; wd[3] = 32'hA3A3_001C;
    wr(32'h8000_0010, 4'h7, 8'd3, 4, 4'hF, resp, bid);
    chk("bw_bresp", 32'(resp), 32'd0);
    chk("bw_bid", 32'(bid), 32'd7);
    for (int i = 0; i < 4; i++) begin
      exp_rd[i] = wd[i]; exp_rr[i] = 2'b00;
    end
    rd(32'h8000_0010, 4'hC, 8'd3, 1'b1, lat);

    // out-of-range decode
    exp_rd[0] = 32'd0; exp_rr[0] = 2'b11;
    rd(32'h7FFF_FFFC, 4'h1, 8'd0, 1'b0, lat);
    rd(32'h8000_4000, 4'h2, 8'd0, 1'b0, lat);
    wd[0] = 32'hDEAD_BEEF;
    wr(32'h8000_4000, 4'h4, 8'd0, 1, 4'hF, resp, bid);
    chk("oor_bresp", 32'(resp), 32'd3);
    exp_rd[0] = 32'h0000_0413; exp_rr[0] = 2'b00;
    rd(32'h8000_0000, 4'h0, 8'd0, 1'b0, lat);
    wd[0] = 32'h5A5A_1234;
    wr(32'h8000_3FFC, 4'h6, 8'd0, 1, 4'hF, resp, bid);
    chk("top_bresp", 32'(resp), 32'd0);
    exp_rd[0] = 32'h5A5A_1234;
    rd(32'h8000_3FFC, 4'h6, 8'd0, 1'b0, lat);

    // burst-length protocol errors
    wd[0] = 32'h1; wd[1] = 32'h2;
    wr(32'h8000_0040, 4'h8, 8'd1, 1, 4'hF, resp, bid);
    chk("early_wlast", 32'(resp), 32'd2);
    wr(32'h8000_0040, 4'h8, 8'd0, 2, 4'hF, resp, bid);
    chk("missing_wlast", 32'(resp), 32'd2);

    // simultaneous AW and AR: write wins, read sees new data
    bus.awaddr = 32'h8000_0020; bus.awid = 4'hA; bus.awlen = 0; bus.awsize = 3'd2; bus.awburst = 2'b01;
    bus.araddr = 32'h8000_0020; bus.arid = 4'hB; bus.arlen = 0; bus.arsize = 3'd2; bus.arburst = 2'b01;
    bus.awvalid = 1'b1; bus.arvalid = 1'b1;
    @(negedge clk);
    chk("both_awready", 32'(bus.awready), 32'd1);
    chk("both_arready", 32'(bus.arready), 32'd0);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wlast = 1'b1;
    @(negedge clk);
    chk("wd_wready", 32'(bus.wready), 32'd1);
    chk("wd_arready", 32'(bus.arready), 32'd0);
    @(posedge clk); #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    @(negedge clk);
    chk("wr_bvalid", 32'(bus.bvalid), 32'd1);
    chk("wr_arready", 32'(bus.arready), 32'd0);
    @(posedge clk); #1;
    bus.bready = 1'b0;
    @(negedge clk);
    chk("after_b_arready", 32'(bus.arready), 32'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      @(negedge clk);
      if (bus.rvalid) begin
        ok = 1'b1;
        chk("both_rdata", bus.rdata, 32'hCAFE_F00D);
        chk("both_rid", 32'(bus.rid), 32'hB);
      end
      @(posedge clk); #1;
    end
    bus.rready = 1'b0;
    chk("both_rvalid_seen", 32'(ok), 32'd1);

    // reset while in RD_WAIT
    bus.araddr = 32'h8000_0000; bus.arid = 4'h3; bus.arlen = 0; bus.arvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk); ok = bus.arready; @(posedge clk); #1;
    end
    bus.arvalid = 1'b0;
    chk("rst_ar_handshake", 32'(ok), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("midrst_arready", 32'(bus.arready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_arready", 32'(bus.arready), 32'd1);
    chk("post_rst_rvalid", 32'(bus.rvalid), 32'd0);
    @(posedge clk); #1;
    exp_rd[0] = 32'h0000_0413; exp_rr[0] = 2'b00;
    rd(32'h8000_0000, 4'h3, 8'd0, 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 slave memory model that sits directly downstream of the core's AXI master port and answers its io_master_* requests.
- Serves instruction fetches, loads and stores from an internal word-addressed SRAM array.
- Adds configurable read latency so the master's handshake waits get exercised.
- Used in the NPC simulation top and later as an on-chip SRAM behind the crossbar.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH_WORDS, 4096, number of 32-bit words; must be a power of two.
- READ_LATENCY, 2, cycles from AR handshake to first rvalid; minimum 1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- io_slave_awready  out  1  write address ready
- io_slave_awvalid  in  1  write address valid
- io_slave_awaddr  in  32  write byte address
- io_slave_awid  in  4  write ID
- io_slave_awlen  in  8  beats minus 1
- io_slave_awsize  in  3  bytes per beat, log2
- io_slave_awburst  in  2  burst type
- io_slave_wready  out  1  write data ready
- io_slave_wvalid  in  1  write data valid
- io_slave_wdata  in  32  write data
- io_slave_wstrb  in  4  byte strobes
- io_slave_wlast  in  1  last write beat
- io_slave_bready  in  1  response ready
- io_slave_bvalid  out  1  response valid
- io_slave_bresp  out  2  write response
- io_slave_bid  out  4  echoed awid
- io_slave_arready  out  1  read address ready
- io_slave_arvalid  in  1  read address valid
- io_slave_araddr  in  32  read byte address
- io_slave_arid  in  4  read ID
- io_slave_arlen  in  8  beats minus 1
- io_slave_arsize  in  3  bytes per beat, log2
- io_slave_arburst  in  2  burst type
- io_slave_rready  in  1  read data ready
- io_slave_rvalid  out  1  read data valid
- io_slave_rresp  out  2  read response
- io_slave_rdata  out  32  read data
- io_slave_rlast  out  1  last read beat
- io_slave_rid  out  4  echoed arid

Behaviour:
- Reset (reset==0, async): state=IDLE; all ready/valid outputs 0; rresp/bresp/rdata/rid/bid 0; rlast 0. SRAM contents are not reset.
- One outstanding transaction at a time. FSM states: IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP.
- IDLE:
  - arready=1 and awready=1, except: if awvalid is 1, arready is 0 (write has priority when both arrive).
  - AW handshake: latch awaddr/awid/awlen, clear error flag -> WR_DATA.
  - AR handshake: latch araddr/arid/arlen, load latency counter with READ_LATENCY-1 -> RD_WAIT.
- RD_WAIT: counter decrements each cycle; at 0 -> RD_DATA.
- RD_DATA:
  - rvalid=1; rdata = SRAM word at the current word-aligned address; rid = latched arid; rlast = (beat counter == arlen).
  - rdata/rresp/rlast hold stable while rvalid=1 and rready=0.
  - On handshake: address += 4 (INCR; FIXED keeps the address; WRAP is treated as INCR), beat counter +1.
  - Handshake on the last beat -> IDLE.
  - No latency between later beats of a burst.
- WR_DATA:
  - wready=1.
  - Each W handshake writes the bytes enabled by wstrb into the addressed word (strb[i] selects bits 8i+7:8i); address advances as for reads.
  - The write is visible to a read accepted in the following cycle or later.
  - After the wlast handshake -> WR_RESP.
  - If wlast arrives before awlen+1 beats, or awlen+1 beats arrive without wlast, bresp=SLVERR (2'b10).
- WR_RESP: bvalid=1, bid = latched awid; held until bready; then -> IDLE.
- Narrow accesses (size 0/1): full aligned word returned on rdata; writes rely on wstrb only.
- Address decode:
  - Word index = (addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits.
  - Out of range = addr < BASE_ADDR or addr >= BASE_ADDR+4*DEPTH_WORDS, checked per beat.
  - Out-of-range read beat: rresp=DECERR (2'b11), rdata=0.
  - Out-of-range write beat: SRAM not written; bresp=DECERR unless SLVERR is already pending.
  - Otherwise rresp/bresp = OKAY (2'b00).
- Address wrap past 32'hFFFF_FFFC wraps to 0 and decodes as out of range.
- Asserting reset mid-transaction aborts it immediately; the master must reissue the request.

Optional Feature:
- Macro AXI_SRAM_RAND_DELAY_EN.
- Defined:
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset) advances every cycle.
  - IDLE readies are gated low for LFSR[2:0] cycles after any transaction completes.
  - Each RD_DATA beat after the first is preceded by LFSR[1:0] idle cycles with rvalid=0.
- Undefined: timing exactly as in Behaviour. Functional results are identical either way.

Test Plan:
- Reset, then write 32'h0000_0413 to 32'h8000_0000 with wstrb=4'hF -> bvalid after the wlast handshake, bresp=00, bid=awid; a read of 32'h8000_0000 then returns rdata=32'h0000_0413 exactly 2 cycles after the AR handshake, rlast=1.
- Write 32'hAABBCCDD with wstrb=4'b0100 over 32'h1122_3344 -> readback 32'h11BB_3344.
- 4-beat INCR read (arlen=3) from 32'h8000_0010 with rready toggling 1,0,1,0 -> four words at 0x10/0x14/0x18/0x1C in order, rdata stable while stalled, rlast only on beat 4.
- Read 32'h7FFF_FFFC and 32'h8000_4000 -> rresp=2'b11, rdata=0; write 32'h8000_4000 -> bresp=2'b11, no SRAM location changed.
- AW and AR valid in the same cycle -> awready=1, arready=0; the read is accepted only after the B handshake and returns the newly written data.
- Drive reset low while in RD_WAIT -> rvalid=0 immediately; after release state=IDLE and arready=1 on the first cycle.
